// File: rtl/nroot_pkg.sv
// nroot_pkg: shared types and constants for the N-th root Taylor-series datapath
// Contents: state_t (IDLE/ACCUM/DONE), ACC_WIDTH, CNT_W, SAT_POS/SAT_NEG clamp values
package nroot_pkg;
  localparam int ACC_WIDTH = 128;
  localparam int CNT_W = 8;
  localparam logic [ACC_WIDTH-1:0] SAT_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/taylor_term_accum_fa.sv
// FA_128: 128-bit ripple-carry adder
// Ports: a, b (addends), cin (carry in), s (sum, carry out dropped)
module FA_128
  import nroot_pkg::*;
(
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [ACC_WIDTH-1:0] s
);
  logic c;
  always_comb begin
    c = cin;
    s = '0;
    for (int k = 0; k < ACC_WIDTH; k++) begin
      s[k] = a[k] ^ b[k] ^ c;
      c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
  end
endmodule

// File: rtl/taylor_term_accum.sv
// taylor_term_accum: signed streaming accumulator of Taylor-series terms
// Ports: clk, rst_n (async active-low); start/n_terms begin a run; term_valid/term_ready/term/term_sub
// stream terms in; sum/sum_valid/sum_ready hand the result out; busy, overflow (sticky per run).
// Optional: define TAYLOR_ACC_SATURATE_EN to clamp the sum on signed overflow instead of wrapping.
module taylor_term_accum
  import nroot_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = nroot_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [WIDTH-1:0] term,
  input  logic             term_sub,
  output logic [WIDTH-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             overflow
);
  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] acc_next;
  logic             op_sign;
  logic             ovf_now;
  logic             take;
  assign operand = term_sub ? ~term + 1'b1 : term;
  FA_128 u_add (.a(acc), .b(operand), .cin(1'b0), .s(add_sum));
  // Negating -2^127 wraps back to itself; its true value is +2^127, so treat it as positive.
  assign op_sign = (term_sub && term == SAT_NEG) ? 1'b0 : operand[WIDTH-1];
  assign ovf_now = (op_sign == acc[WIDTH-1]) && (add_sum[WIDTH-1] != acc[WIDTH-1]);
`ifdef TAYLOR_ACC_SATURATE_EN
  assign acc_next = ovf_now ? (acc[WIDTH-1] ? SAT_NEG : SAT_POS) : add_sum;
`else
  assign acc_next = add_sum;
`endif
  assign term_ready = state == ACCUM;
  assign take = term_valid && term_ready;
  assign sum_valid = state == DONE;
  assign busy = state != IDLE;
  assign sum = sum_valid ? acc : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      remaining <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      overflow <= 1'b0;
      remaining <= n_terms;
      state <= n_terms == '0 ? DONE : ACCUM;
    end else if (take) begin
      acc <= acc_next;
      overflow <= overflow | ovf_now;
      remaining <= remaining - 1'b1;
      if (remaining == CNT_W'(1)) state <= DONE;
    end else if (state == DONE && sum_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_taylor_term_accum.sv
// tb_taylor_term_accum: directed self-checking bench for taylor_term_accum
module tb_taylor_term_accum;
  localparam logic [127:0] MAXP = {1'b0, {127{1'b1}}};
  localparam logic [127:0] MINN = {1'b1, {127{1'b0}}};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] n_terms = '0;
  logic term_valid = 1'b0;
  logic term_ready;
  logic [127:0] term = '0;
  logic term_sub = 1'b0;
  logic [127:0] sum;
  logic sum_valid;
  logic sum_ready = 1'b0;
  logic busy;
  logic overflow;
  int total = 0;
  int passed = 0;
  taylor_term_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
    .term_valid(term_valid), .term_ready(term_ready), .term(term), .term_sub(term_sub),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    n_terms = n;
    step();
    start = 1'b0;
  endtask
  task automatic send(input logic [127:0] t, input logic sub);
    term_valid = 1'b1;
    term = t;
    term_sub = sub;
    step();
    term_valid = 1'b0;
  endtask
  task automatic release_sum();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (term_ready !== 1'b0) $display("FAIL reset_term_ready got %b exp 0", term_ready); else passed++;
    total++; if (sum_valid !== 1'b0) $display("FAIL reset_sum_valid got %b exp 0", sum_valid); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
    total++; if (sum !== 128'd0) $display("FAIL reset_sum got %h exp 0", sum); else passed++;
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_basic();
    do_start(8'd3);
    total++; if (term_ready !== 1'b1) $display("FAIL basic_ready got %b exp 1", term_ready); else passed++;
    send(128'd5, 1'b0);
    send(128'd7, 1'b0);
    total++; if (sum_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", sum_valid); else passed++;
    send(128'd2, 1'b1);
    total++; if (sum_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", sum_valid); else passed++;
    total++; if (sum !== 128'd10) $display("FAIL basic_sum got %0d exp 10", sum); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL basic_overflow got %b exp 0", overflow); else passed++;
    total++; if (term_ready !== 1'b0) $display("FAIL basic_done_ready got %b exp 0", term_ready); else passed++;
    release_sum();
    total++; if (busy !== 1'b0 || sum_valid !== 1'b0) $display("FAIL basic_idle got busy=%b valid=%b exp 0/0", busy, sum_valid); else passed++;
  endtask
  task automatic test_zero_terms();
    do_start(8'd0);
    total++; if (sum_valid !== 1'b1) $display("FAIL zero_valid got %b exp 1", sum_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (sum_valid !== 1'b1 || sum !== 128'd0) $display("FAIL zero_hold%0d got valid=%b sum=%h exp 1/0", i, sum_valid, sum); else passed++;
    end
    release_sum();
    total++; if (sum_valid !== 1'b0) $display("FAIL zero_clear got %b exp 0", sum_valid); else passed++;
  endtask
  task automatic test_overflow();
    logic [127:0] exp_sum;
`ifdef TAYLOR_ACC_SATURATE_EN
    exp_sum = MAXP;
`else
    exp_sum = MINN;
`endif
    do_start(8'd2);
    send(MAXP, 1'b0);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", overflow); else passed++;
    send(128'd1, 1'b0);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else passed++;
    total++; if (sum !== exp_sum) $display("FAIL ovf_sum got %h exp %h", sum, exp_sum); else passed++;
    step();
    step();
    total++; if (overflow !== 1'b1 || sum !== exp_sum || sum_valid !== 1'b1) $display("FAIL ovf_hold got ovf=%b sum=%h valid=%b exp 1/%h/1", overflow, sum, sum_valid, exp_sum); else passed++;
    release_sum();
  endtask
  task automatic test_gaps();
    do_start(8'd4);
    total++; if (overflow !== 1'b0) $display("FAIL gaps_ovf_cleared got %b exp 0", overflow); else passed++;
    for (int i = 1; i <= 4; i++) begin
      send(128'(i), 1'b0);
      if (i < 4) begin
        start = 1'b1;
        n_terms = 8'd1;
        step();
        start = 1'b0;
        total++; if (sum_valid !== 1'b0 || term_ready !== 1'b1) $display("FAIL gaps_idle%0d got valid=%b ready=%b exp 0/1", i, sum_valid, term_ready); else passed++;
      end
    end
    total++; if (sum_valid !== 1'b1 || sum !== 128'd10) $display("FAIL gaps_sum got valid=%b sum=%0d exp 1/10", sum_valid, sum); else passed++;
    send(128'd100, 1'b0);
    total++; if (sum !== 128'd10) $display("FAIL gaps_done_ignore got %0d exp 10", sum); else passed++;
    release_sum();
  endtask
  task automatic test_reset_mid();
    do_start(8'd5);
    send(128'd1, 1'b0);
    send(128'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || term_ready !== 1'b0 || sum_valid !== 1'b0) $display("FAIL midrst_ctrl got busy=%b ready=%b valid=%b exp 0/0/0", busy, term_ready, sum_valid); else passed++;
    total++; if (sum !== 128'd0 || overflow !== 1'b0) $display("FAIL midrst_data got sum=%h ovf=%b exp 0/0", sum, overflow); else passed++;
    step();
    rst_n = 1'b1;
    step();
    do_start(8'd1);
    send(128'd9, 1'b0);
    total++; if (sum_valid !== 1'b1 || sum !== 128'd9) $display("FAIL midrst_rerun got valid=%b sum=%0d exp 1/9", sum_valid, sum); else passed++;
    release_sum();
  endtask
  task automatic test_neg_min();
    logic [127:0] exp_sum;
`ifdef TAYLOR_ACC_SATURATE_EN
    exp_sum = MAXP;
`else
    exp_sum = MINN;
`endif
    do_start(8'd1);
    send(MINN, 1'b1);
    total++; if (overflow !== 1'b1) $display("FAIL negmin_ovf got %b exp 1", overflow); else passed++;
    total++; if (sum !== exp_sum) $display("FAIL negmin_sum got %h exp %h", sum, exp_sum); else passed++;
    release_sum();
    do_start(8'd2);
    send(128'd3, 1'b1);
    send(128'd1, 1'b0);
    total++; if (sum !== {128{1'b1}} - 128'd1 || overflow !== 1'b0) $display("FAIL negsum got sum=%h ovf=%b exp -2/0", sum, overflow); else passed++;
    release_sum();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero_terms();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_neg_min();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
